// File: rtl/pgs_tsmac_stat_pkg.sv
// Shared constants for the TSMAC receive-statistics counter bank.
// Saturating counters are selected by TSMAC_STAT_SATURATE_EN; this package does not depend on it.
package pgs_tsmac_stat_pkg;

  localparam int NUM_STAT = 10;
  localparam int NUM_FLAG = 9;

  // Bit positions inside the rx_stat end-of-frame vector
  localparam int STAT_CRC_ERR   = 0;
  localparam int STAT_PAUSE_CTR = 1;
  localparam int STAT_ADDR_ERR  = 2;
  localparam int STAT_LEN_ERR   = 3;
  localparam int STAT_FRAME_TRC = 4;
  localparam int STAT_IFG_SMA   = 5;
  localparam int STAT_BCAD      = 6;
  localparam int STAT_MCAD      = 7;
  localparam int STAT_UCAD      = 8;

  // Output order of the counter bank, also the bit order of stat_ovf
  typedef enum logic [3:0] {
    OUT_PACKET    = 4'd0,
    OUT_CRC_ERR   = 4'd1,
    OUT_PAUSE_CTR = 4'd2,
    OUT_ADDR_ERR  = 4'd3,
    OUT_LEN_ERR   = 4'd4,
    OUT_FRAME_TRC = 4'd5,
    OUT_IFG_SMA   = 4'd6,
    OUT_BCAD      = 4'd7,
    OUT_MCAD      = 4'd8,
    OUT_UCAD      = 4'd9
  } stat_out_e;

endpackage

// File: rtl/pgs_tsmac_stat_ctr.sv
// One statistics counter: live register, host-visible shadow and sticky overflow flag.
// Define TSMAC_STAT_SATURATE_EN to hold at all-ones instead of wrapping to zero.
module pgs_tsmac_stat_ctr #(
  parameter int CNT_W = 64
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        inc_i,
  input  logic        clr_i,
  input  logic        freeze_i,
  output logic [63:0] cnt_o,
  output logic        ovf_o
);

  localparam logic [CNT_W-1:0] ALL_ONES = '1;
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  logic [CNT_W-1:0] live_q, live_d;
  logic [CNT_W-1:0] shadow_q, shadow_d;
  logic             ovf_q, ovf_d;

  always_comb begin
    live_d   = live_q;
    shadow_d = shadow_q;
    ovf_d    = ovf_q;
    if (inc_i) begin
      if (live_q == ALL_ONES) begin
        ovf_d = 1'b1;
`ifdef TSMAC_STAT_SATURATE_EN
        live_d = ALL_ONES;
`else
        live_d = '0;
`endif
      end else begin
        live_d = live_q + ONE;
      end
    end
    // Shadow takes the pre-increment live value, which adds the third pipeline cycle
    if (!freeze_i) begin
      shadow_d = live_q;
    end
    if (clr_i) begin
      live_d   = '0;
      shadow_d = '0;
      ovf_d    = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      live_q   <= '0;
      shadow_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      live_q   <= live_d;
      shadow_q <= shadow_d;
      ovf_q    <= ovf_d;
    end
  end

  assign cnt_o = 64'(shadow_q);
  assign ovf_o = ovf_q;

endmodule

// File: rtl/pgs_tsmac_rx_stat_cnt.sv
// RX statistics counter bank: stage-1 status register feeding ten pgs_tsmac_stat_ctr instances.
// Define TSMAC_STAT_SATURATE_EN for saturating counters; default build wraps.
module pgs_tsmac_rx_stat_cnt
  import pgs_tsmac_stat_pkg::*;
#(
  parameter int CNT_W = 64,
  parameter int TP    = 1
) (
  input  logic                hstclk,
  input  logic                hstrst,
  input  logic                rx_stat_vld,
  input  logic [NUM_FLAG-1:0] rx_stat,
  input  logic                cnt_freeze,
  input  logic                cnt_clr,
  output logic [63:0]         packet_cnt,
  output logic [63:0]         crc_err_cnt,
  output logic [63:0]         pause_ctr_cnt,
  output logic [63:0]         addr_err_cnt,
  output logic [63:0]         len_err_cnt,
  output logic [63:0]         frame_trc_cnt,
  output logic [63:0]         ifg_sma_cnt,
  output logic [63:0]         bcad_cnt,
  output logic [63:0]         mcad_cnt,
  output logic [63:0]         ucad_cnt,
  output logic [NUM_STAT-1:0] stat_ovf
);

  if (CNT_W < 1 || CNT_W > 64 || TP < 0) begin : g_bad_cfg
    $error("pgs_tsmac_rx_stat_cnt: CNT_W must be 1..64 and TP non-negative");
  end

  // rx_stat_vld is a single-cycle qualifier with no back-pressure: rx_stat is
  // meaningful only in a cycle where rx_stat_vld=1, and every such cycle is accepted.
  logic                s1_vld_q, s1_vld_d;
  logic [NUM_FLAG-1:0] s1_stat_q, s1_stat_d;
  logic [NUM_STAT-1:0] inc;
  logic [63:0]         cnt_sh [NUM_STAT];

  // A vector arriving alongside cnt_clr is dropped so counting restarts cleanly
  always_comb begin
    s1_vld_d  = rx_stat_vld & ~cnt_clr;
    s1_stat_d = rx_stat_vld ? rx_stat : '0;
  end

  always_ff @(posedge hstclk) begin
    if (hstrst) begin
      s1_vld_q  <= 1'b0;
      s1_stat_q <= '0;
    end else begin
      s1_vld_q  <= s1_vld_d;
      s1_stat_q <= s1_stat_d;
    end
  end

  always_comb begin
    inc                = '0;
    inc[OUT_PACKET]    = s1_vld_q;
    inc[OUT_CRC_ERR]   = s1_vld_q & s1_stat_q[STAT_CRC_ERR];
    inc[OUT_PAUSE_CTR] = s1_vld_q & s1_stat_q[STAT_PAUSE_CTR];
    inc[OUT_ADDR_ERR]  = s1_vld_q & s1_stat_q[STAT_ADDR_ERR];
    inc[OUT_LEN_ERR]   = s1_vld_q & s1_stat_q[STAT_LEN_ERR];
    inc[OUT_FRAME_TRC] = s1_vld_q & s1_stat_q[STAT_FRAME_TRC];
    inc[OUT_IFG_SMA]   = s1_vld_q & s1_stat_q[STAT_IFG_SMA];
    inc[OUT_BCAD]      = s1_vld_q & s1_stat_q[STAT_BCAD];
    inc[OUT_MCAD]      = s1_vld_q & s1_stat_q[STAT_MCAD];
    inc[OUT_UCAD]      = s1_vld_q & s1_stat_q[STAT_UCAD];
  end

  for (genvar g = 0; g < NUM_STAT; g++) begin : g_ctr
    pgs_tsmac_stat_ctr #(
      .CNT_W (CNT_W)
    ) u_ctr (
      .clk_i    (hstclk),
      .rst_i    (hstrst),
      .inc_i    (inc[g]),
      .clr_i    (cnt_clr),
      .freeze_i (cnt_freeze),
      .cnt_o    (cnt_sh[g]),
      .ovf_o    (stat_ovf[g])
    );
  end

  assign packet_cnt    = cnt_sh[OUT_PACKET];
  assign crc_err_cnt   = cnt_sh[OUT_CRC_ERR];
  assign pause_ctr_cnt = cnt_sh[OUT_PAUSE_CTR];
  assign addr_err_cnt  = cnt_sh[OUT_ADDR_ERR];
  assign len_err_cnt   = cnt_sh[OUT_LEN_ERR];
  assign frame_trc_cnt = cnt_sh[OUT_FRAME_TRC];
  assign ifg_sma_cnt   = cnt_sh[OUT_IFG_SMA];
  assign bcad_cnt      = cnt_sh[OUT_BCAD];
  assign mcad_cnt      = cnt_sh[OUT_MCAD];
  assign ucad_cnt      = cnt_sh[OUT_UCAD];

endmodule

// File: tb/tb_pgs_tsmac_rx_stat_cnt.sv
// Bench for pgs_tsmac_rx_stat_cnt (CNT_W=8): directed scenarios plus random traffic,
// scored every cycle against totals-based reference; honours TSMAC_STAT_SATURATE_EN.
module tb_pgs_tsmac_rx_stat_cnt;

  localparam int              CW   = 8;
  localparam longint unsigned MAXV = (64'd1 << CW) - 1;
  localparam int              EW   = 650;

  // Clock / reset and DUT
  logic        hstclk = 1'b0;
  logic        hstrst = 1'b1;
  logic        rx_stat_vld = 1'b0;
  logic [8:0]  rx_stat = '0;
  logic        cnt_freeze = 1'b0;
  logic        cnt_clr = 1'b0;
  logic [63:0] packet_cnt, crc_err_cnt, pause_ctr_cnt, addr_err_cnt, len_err_cnt;
  logic [63:0] frame_trc_cnt, ifg_sma_cnt, bcad_cnt, mcad_cnt, ucad_cnt;
  logic [9:0]  stat_ovf;

  always #5 hstclk = ~hstclk;

  pgs_tsmac_rx_stat_cnt #(.CNT_W(CW), .TP(1)) dut (
    .hstclk        (hstclk),
    .hstrst        (hstrst),
    .rx_stat_vld   (rx_stat_vld),
    .rx_stat       (rx_stat),
    .cnt_freeze    (cnt_freeze),
    .cnt_clr       (cnt_clr),
    .packet_cnt    (packet_cnt),
    .crc_err_cnt   (crc_err_cnt),
    .pause_ctr_cnt (pause_ctr_cnt),
    .addr_err_cnt  (addr_err_cnt),
    .len_err_cnt   (len_err_cnt),
    .frame_trc_cnt (frame_trc_cnt),
    .ifg_sma_cnt   (ifg_sma_cnt),
    .bcad_cnt      (bcad_cnt),
    .mcad_cnt      (mcad_cnt),
    .ucad_cnt      (ucad_cnt),
    .stat_ovf      (stat_ovf)
  );

  logic [63:0] out_v [10];
  assign out_v[0] = packet_cnt;
  assign out_v[1] = crc_err_cnt;
  assign out_v[2] = pause_ctr_cnt;
  assign out_v[3] = addr_err_cnt;
  assign out_v[4] = len_err_cnt;
  assign out_v[5] = frame_trc_cnt;
  assign out_v[6] = ifg_sma_cnt;
  assign out_v[7] = bcad_cnt;
  assign out_v[8] = mcad_cnt;
  assign out_v[9] = ucad_cnt;

  string names [10] = '{"packet", "crc_err", "pause_ctr", "addr_err", "len_err",
                        "frame_trc", "ifg_sma", "bcad", "mcad", "ucad"};

  int errors = 0;
  int checks = 0;

  // Reference model: unbounded event totals since the last clear, one snapshot per edge.
  // Live value at edge t reflects events sampled up to t-1; the shadow copies the
  // value from t-2 whenever not frozen. The visible value is the total folded into CW bits.
  typedef struct { longint unsigned c[10]; } snap_t;
  snap_t           tot;
  snap_t           hist_q[$];
  longint unsigned m_shadow [10];
  logic [EW-1:0]   exp_q[$];

  function automatic longint unsigned shown(input longint unsigned raw);
`ifdef TSMAC_STAT_SATURATE_EN
    return (raw > MAXV) ? MAXV : raw;
`else
    return raw & MAXV;
`endif
  endfunction

  initial begin
    for (int i = 0; i < 10; i++) begin
      tot.c[i]    = 0;
      m_shadow[i] = 0;
    end
    hist_q.push_back(tot);
    hist_q.push_back(tot);
  end

  always @(posedge hstclk) begin : model
    logic [EW-1:0] e;
    e = '0;
    if (hstrst || cnt_clr) begin
      for (int i = 0; i < 10; i++) begin
        tot.c[i]    = 0;
        m_shadow[i] = 0;
      end
      hist_q.delete();
      hist_q.push_back(tot);
      hist_q.push_back(tot);
    end else begin
      if (rx_stat_vld) begin
        tot.c[0]++;
        for (int i = 0; i < 9; i++)
          if (rx_stat[i]) tot.c[i+1]++;
      end
      hist_q.push_back(tot);
      while (hist_q.size() > 3) void'(hist_q.pop_front());
      for (int i = 0; i < 10; i++) begin
        if (!cnt_freeze) m_shadow[i] = shown(hist_q[0].c[i]);
        e[i*64 +: 64] = m_shadow[i];
        e[640+i]      = (hist_q[1].c[i] > MAXV);
      end
    end
    exp_q.push_back(e);
  end

  // Scoreboard monitor: one expected snapshot per edge, compared half a cycle later
  always @(negedge hstclk) begin : monitor
    logic [EW-1:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_empty t=%0t got=no_expectation exp=one_per_edge", $time);
    end else begin
      e = exp_q.pop_front();
      for (int i = 0; i < 10; i++) begin
        checks++;
        if (out_v[i] !== e[i*64 +: 64]) begin
          errors++;
          $display("FAIL sb_%s_cnt t=%0t got=%0d exp=%0d", names[i], $time, out_v[i], e[i*64 +: 64]);
        end
      end
      checks++;
      if (stat_ovf !== e[649:640]) begin
        errors++;
        $display("FAIL sb_stat_ovf t=%0t got=%b exp=%b", $time, stat_ovf, e[649:640]);
      end
    end
  end

  // Driver tasks
  task automatic step(input logic r, input logic v, input logic [8:0] s,
                      input logic f, input logic c);
    @(negedge hstclk);
    hstrst      = r;
    rx_stat_vld = v;
    rx_stat     = s;
    cnt_freeze  = f;
    cnt_clr     = c;
  endtask

  task automatic idle(input int n, input logic f);
    repeat (n) step(1'b0, 1'b0, 9'h000, f, 1'b0);
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%0d exp=%0d", nm, $time, act, exp);
    end
  endtask

  logic frz;

  initial begin : stimulus
    repeat (3) step(1'b1, 1'b0, 9'h000, 1'b0, 1'b0);
    chk("reset_packet", packet_cnt, 64'd0);
    chk("reset_ovf", 64'(stat_ovf), 64'd0);

    // Single frame with crc_err and bcad
    step(1'b0, 1'b1, 9'h041, 1'b0, 1'b0);
    idle(4, 1'b0);
    chk("single_packet", packet_cnt, 64'd1);
    chk("single_crc", crc_err_cnt, 64'd1);
    chk("single_bcad", bcad_cnt, 64'd1);
    chk("single_mcad", mcad_cnt, 64'd0);
    chk("single_ovf", 64'(stat_ovf), 64'd0);

    // 100 back-to-back unicast frames
    step(1'b0, 1'b0, 9'h000, 1'b0, 1'b1);
    idle(2, 1'b0);
    repeat (100) step(1'b0, 1'b1, 9'h100, 1'b0, 1'b0);
    idle(4, 1'b0);
    chk("burst_packet", packet_cnt, 64'd100);
    chk("burst_ucad", ucad_cnt, 64'd100);
    chk("burst_crc", crc_err_cnt, 64'd0);

    // Freeze holds the shadow while live counting continues
    step(1'b0, 1'b0, 9'h000, 1'b0, 1'b1);
    idle(2, 1'b0);
    repeat (5) step(1'b0, 1'b1, 9'h000, 1'b0, 1'b0);
    idle(3, 1'b0);
    repeat (7) step(1'b0, 1'b1, 9'h000, 1'b1, 1'b0);
    idle(4, 1'b1);
    chk("frozen_packet", packet_cnt, 64'd5);
    step(1'b0, 1'b0, 9'h000, 1'b0, 1'b0);
    step(1'b0, 1'b0, 9'h000, 1'b0, 1'b0);
    chk("unfrozen_packet", packet_cnt, 64'd12);

    // Counter boundary: 256 frames into an 8-bit counter
    step(1'b0, 1'b0, 9'h000, 1'b0, 1'b1);
    idle(2, 1'b0);
    repeat (256) step(1'b0, 1'b1, 9'h000, 1'b0, 1'b0);
    idle(4, 1'b0);
`ifdef TSMAC_STAT_SATURATE_EN
    chk("wrap_packet", packet_cnt, 64'd255);
`else
    chk("wrap_packet", packet_cnt, 64'd0);
`endif
    chk("wrap_ovf", 64'(stat_ovf), 64'd1);
    repeat (4) step(1'b0, 1'b1, 9'h000, 1'b0, 1'b0);
    idle(4, 1'b0);
`ifdef TSMAC_STAT_SATURATE_EN
    chk("post_wrap_packet", packet_cnt, 64'd255);
`else
    chk("post_wrap_packet", packet_cnt, 64'd4);
`endif
    chk("post_wrap_ovf_sticky", 64'(stat_ovf), 64'd1);

    // Clear coinciding with one new event and one in stage 1
    step(1'b0, 1'b0, 9'h000, 1'b0, 1'b1);
    idle(2, 1'b0);
    repeat (3) step(1'b0, 1'b1, 9'h1FF, 1'b0, 1'b0);
    idle(4, 1'b0);
    chk("preclr_packet", packet_cnt, 64'd3);
    step(1'b0, 1'b1, 9'h1FF, 1'b0, 1'b0);
    step(1'b0, 1'b1, 9'h1FF, 1'b1, 1'b1);
    idle(4, 1'b0);
    chk("clr_packet", packet_cnt, 64'd0);
    chk("clr_crc", crc_err_cnt, 64'd0);
    chk("clr_ucad", ucad_cnt, 64'd0);
    chk("clr_ovf", 64'(stat_ovf), 64'd0);
    step(1'b0, 1'b1, 9'h000, 1'b0, 1'b0);
    idle(4, 1'b0);
    chk("postclr_packet", packet_cnt, 64'd1);
    chk("postclr_crc", crc_err_cnt, 64'd0);

    // Reset mid-burst with an event in stage 1
    repeat (3) step(1'b0, 1'b1, 9'h0FF, 1'b0, 1'b0);
    step(1'b1, 1'b0, 9'h000, 1'b0, 1'b0);
    step(1'b0, 1'b0, 9'h000, 1'b0, 1'b0);
    chk("rst_packet", packet_cnt, 64'd0);
    chk("rst_ovf", 64'(stat_ovf), 64'd0);
    idle(4, 1'b0);
    chk("rst_drain_packet", packet_cnt, 64'd0);
    chk("rst_drain_crc", crc_err_cnt, 64'd0);

    // Random traffic with freeze toggles, sparse clears and resets
    frz = 1'b0;
    for (int n = 0; n < 1200; n++) begin
      if ($urandom_range(0, 15) == 0) frz = ~frz;
      step(($urandom_range(0, 299) == 0), ($urandom_range(0, 3) != 0),
           9'($urandom_range(0, 511)), frz, ($urandom_range(0, 149) == 0));
    end
    idle(4, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
